// File: rtl/hub75_scan_ctrl_if.sv
// rtl/hub75_scan_ctrl_if.sv - framebuffer read port and HUB75 panel pins of the scan controller
//   bram_r_en/bram_r_addr/bram_r_data : framebuffer BRAM read port
//   hub_clk/hub_rgb/hub_lat/hub_oe_n/hub_addr : HUB75 panel pins
//   master modport = scan controller side, slave modport = BRAM/panel side
interface hub75_scan_ctrl_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 9,
    parameter int ROW_WIDTH  = 4
);
    logic                  bram_r_en;
    logic [ADDR_WIDTH-1:0] bram_r_addr;
    logic [DATA_WIDTH-1:0] bram_r_data;
    logic                  hub_clk;
    logic [DATA_WIDTH-1:0] hub_rgb;
    logic                  hub_lat;
    logic                  hub_oe_n;
    logic [ROW_WIDTH-1:0]  hub_addr;

    modport master (
        output bram_r_en, bram_r_addr,
        input  bram_r_data,
        output hub_clk, hub_rgb, hub_lat, hub_oe_n, hub_addr
    );

    modport slave (
        input  bram_r_en, bram_r_addr,
        output bram_r_data,
        input  hub_clk, hub_rgb, hub_lat, hub_oe_n, hub_addr
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 row scan sequencer fed from the framebuffer BRAM read port
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run scan, sampled in IDLE and at the end of each row's display
//   busy         : high in every state but IDLE
//   frame_done   : one-cycle pulse on the last display cycle of the last row
//   bus (master) : BRAM read port and HUB75 pins
// The BRAM read for a column is issued one state ahead of the state that consumes
// its data, so the panel pins (hub_*) and frame_done trail the FSM state by one
// clock; bram_r_en/bram_r_addr/busy are aligned with the state itself.
module hub75_scan_ctrl #(
    parameter int PANEL_WIDTH  = 32,
    parameter int SCAN_ROWS    = 16,
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = $clog2(PANEL_WIDTH * SCAN_ROWS),
    parameter int ON_CYCLES    = 64,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              busy,
    output logic              frame_done,
    hub75_scan_ctrl_if.master bus
);
    localparam int ROW_WIDTH = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
    localparam int COL_WIDTH = (PANEL_WIDTH > 1) ? $clog2(PANEL_WIDTH) : 1;
    localparam int CNT_MAX   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [COL_WIDTH-1:0]  LAST_COL   = COL_WIDTH'(PANEL_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0]  LAST_ROW   = ROW_WIDTH'(SCAN_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_BLANK = CNT_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_ON    = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(PANEL_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t               state;
    logic [ROW_WIDTH-1:0] row;
    logic [ROW_WIDTH-1:0] row_next;
    logic [COL_WIDTH-1:0] col;
    logic [CNT_WIDTH-1:0] cnt;

    assign row_next = (row == LAST_ROW) ? '0 : row + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            row             <= '0;
            col             <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            bus.bram_r_en   <= 1'b0;
            bus.bram_r_addr <= '0;
            bus.hub_clk     <= 1'b0;
            bus.hub_rgb     <= '0;
            bus.hub_lat     <= 1'b0;
            bus.hub_oe_n    <= 1'b1;
            bus.hub_addr    <= '0;
        end else begin
            bus.bram_r_en <= 1'b0;
            bus.hub_lat   <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    bus.hub_clk  <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                    if (enable) begin
                        state           <= PREFETCH;
                        busy            <= 1'b1;
                        col             <= '0;
                        bus.bram_r_en   <= 1'b1;
                        bus.bram_r_addr <= ADDR_WIDTH'(row) * ROW_STRIDE;
                    end
                end
                PREFETCH: begin
                    bus.hub_clk  <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                    state        <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    // Read data for this column is on bram_r_data now; the next
                    // column's read goes out during SHIFT_HI so it lands in time.
                    bus.hub_rgb  <= bus.bram_r_data;
                    bus.hub_clk  <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                    state        <= SHIFT_HI;
                    if (col != LAST_COL) begin
                        bus.bram_r_en   <= 1'b1;
                        bus.bram_r_addr <= bus.bram_r_addr + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    bus.hub_clk <= 1'b1;
                    if (col == LAST_COL) begin
                        state <= BLANK;
                        cnt   <= '0;
                    end else begin
                        col   <= col + 1'b1;
                        state <= SHIFT_LO;
                    end
                end
                BLANK: begin
                    bus.hub_clk  <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                    bus.hub_addr <= row;
                    if (cnt == LAST_BLANK) begin
                        state <= LATCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    bus.hub_lat  <= 1'b1;
                    bus.hub_clk  <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                    state        <= DISPLAY;
                    cnt          <= '0;
                end
                DISPLAY: begin
                    bus.hub_oe_n <= 1'b0;
                    if (cnt == LAST_ON) begin
                        frame_done <= (row == LAST_ROW);
                        row        <= row_next;
                        col        <= '0;
                        if (enable) begin
                            state           <= PREFETCH;
                            bus.bram_r_en   <= 1'b1;
                            bus.bram_r_addr <= ADDR_WIDTH'(row_next) * ROW_STRIDE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    bus.hub_oe_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - self-checking bench for hub75_scan_ctrl
module tb_hub75_scan_ctrl;
    localparam int W  = 32;
    localparam int R  = 16;
    localparam int B  = 2;
    localparam int ON = 64;
    localparam int P  = 1 + 2 * W + B + 1 + ON;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic busy;
    logic frame_done;

    hub75_scan_ctrl_if #(.DATA_WIDTH(6), .ADDR_WIDTH(9), .ROW_WIDTH(4)) bus ();

    hub75_scan_ctrl #(
        .PANEL_WIDTH(W), .SCAN_ROWS(R), .DATA_WIDTH(6), .ADDR_WIDTH(9),
        .ON_CYCLES(ON), .BLANK_CYCLES(B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .busy(busy), .frame_done(frame_done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [5:0] mem [W*R];
    initial for (int k = 0; k < W * R; k++) mem[k] = 6'(k);

    always @(posedge clk) if (bus.bram_r_en) bus.bram_r_data <= mem[bus.bram_r_addr];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Model: a row is a timeline of P positions; j is the position of the current
    // clock, p_* the previous clock, which the panel pins reflect.
    logic run, p_run;
    int   j, p_j, row, p_row;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0; j <= 0; row <= 0;
            p_run <= 1'b0; p_j <= 0; p_row <= 0;
        end else begin
            p_run <= run; p_j <= j; p_row <= row;
            if (!run) begin
                if (enable) begin run <= 1'b1; j <= 0; end
            end else if (j == P - 1) begin
                row <= (row + 1) % R;
                if (enable) j <= 0; else run <= 1'b0;
            end else begin
                j <= j + 1;
            end
        end
    end

    logic prev_clk_c = 1'b0;
    logic [5:0] prev_rgb_c = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_r_en", int'(bus.bram_r_en), 0);
            chk("rst_r_addr", int'(bus.bram_r_addr), 0);
            chk("rst_hub_clk", int'(bus.hub_clk), 0);
            chk("rst_hub_rgb", int'(bus.hub_rgb), 0);
            chk("rst_hub_lat", int'(bus.hub_lat), 0);
            chk("rst_hub_oe_n", int'(bus.hub_oe_n), 1);
            chk("rst_hub_addr", int'(bus.hub_addr), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_frame_done", int'(frame_done), 0);
        end else begin
            automatic int  i = p_j;
            automatic bit  e_ren = run && (j <= 2 * W - 2) && (j % 2 == 0);
            automatic bit  e_clk = p_run && (i >= 1) && (i <= 2 * W) && (i % 2 == 0);
            automatic bit  e_lat = p_run && (i == 2 * W + B + 1);
            automatic bit  e_oen = !(p_run && (i >= 2 * W + B + 2));
            automatic bit  e_fd  = p_run && (i == P - 1) && (p_row == R - 1);
            chk("r_en", int'(bus.bram_r_en), int'(e_ren));
            if (e_ren) chk("r_addr", int'(bus.bram_r_addr), row * W + j / 2);
            chk("busy", int'(busy), int'(run));
            chk("hub_clk", int'(bus.hub_clk), int'(e_clk));
            chk("hub_lat", int'(bus.hub_lat), int'(e_lat));
            chk("hub_oe_n", int'(bus.hub_oe_n), int'(e_oen));
            chk("frame_done", int'(frame_done), int'(e_fd));
            if (p_run && i >= 1 && i <= 2 * W)
                chk("hub_rgb", int'(bus.hub_rgb), int'(mem[p_row * W + (i - 1) / 2]));
            if (p_run && i >= 2 * W + 1)
                chk("hub_addr", int'(bus.hub_addr), p_row);
            chk("lat_with_oe", int'(bus.hub_lat & ~bus.hub_oe_n), 0);
            if (bus.hub_lat) chk("clk_during_lat", int'(bus.hub_clk), 0);
            if (bus.hub_clk && !prev_clk_c)
                chk("rgb_stable_at_rise", int'(bus.hub_rgb), int'(prev_rgb_c));
        end
        prev_clk_c = bus.hub_clk;
        prev_rgb_c = bus.hub_rgb;
    end

    int t = 0;
    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic wait_read(input int bound);
        int k = 0;
        while (!bus.bram_r_en && k < bound) begin step(); k++; end
    endtask

    initial begin
        int s0, k, nrd, nrise, nlat, noe, last_rise, lat_off, saw_row1;
        logic pclk;
        rst_n = 1'b0; enable = 1'b0;
        repeat (5) step();
        #1 rst_n = 1'b1;
        repeat (3) step();
        #1 enable = 1'b1;
        step();
        wait_read(20);
        chk("first_read_seen", int'(bus.bram_r_en), 1);
        s0 = t;

        nrd = 0; nrise = 0; nlat = 0; noe = 0; last_rise = -1; lat_off = -1; saw_row1 = 0;
        pclk = 1'b0;
        for (int off = 0; off <= P; off++) begin
            if (off > 0) step();
            if (bus.bram_r_en && off < P) begin
                chk("row0_read_addr", int'(bus.bram_r_addr), nrd);
                nrd++;
            end
            if (bus.bram_r_en && off == P) begin
                saw_row1 = 1;
                chk("row1_first_addr", int'(bus.bram_r_addr), 32);
            end
            if (bus.hub_clk && !pclk) begin
                chk("row0_rise_rgb", int'(bus.hub_rgb), nrise & 63);
                nrise++;
                last_rise = off;
            end
            pclk = bus.hub_clk;
            if (bus.hub_lat) begin
                nlat++;
                lat_off = off;
                chk("row0_lat_hub_addr", int'(bus.hub_addr), 0);
            end
            if (!bus.hub_oe_n) noe++;
        end
        chk("row0_reads", nrd, 32);
        chk("row0_rises", nrise, 32);
        chk("row0_lat_count", nlat, 1);
        chk("row0_oe_low", noe, 64);
        chk("row0_blank_len", lat_off - last_rise - 1, 2);
        chk("row1_prefetch", saw_row1, 1);

        k = 0;
        while (!frame_done && k < 2300) begin step(); k++; end
        chk("frame_done_offset", t - s0, 2112);
        chk("wrap_read_en", int'(bus.bram_r_en), 1);
        chk("wrap_read_addr", int'(bus.bram_r_addr), 0);
        step();
        chk("frame_done_width", int'(frame_done), 0);

        while (t < s0 + 2112 + 5 * P + 20) step();
        #1 enable = 1'b0;
        k = 0;
        while (busy && k < 300) begin step(); k++; end
        chk("idle_offset", t - s0, 2112 + 6 * P);
        chk("idle_hub_addr", int'(bus.hub_addr), 5);
        repeat (10) step();
        chk("idle_oe_n", int'(bus.hub_oe_n), 1);
        chk("idle_busy", int'(busy), 0);
        #1 enable = 1'b1;
        step();
        wait_read(10);
        chk("resume_read_en", int'(bus.bram_r_en), 1);
        chk("resume_addr", int'(bus.bram_r_addr), 192);

        repeat (50) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe_n", int'(bus.hub_oe_n), 1);
        chk("async_r_en", int'(bus.bram_r_en), 0);
        chk("async_hub_clk", int'(bus.hub_clk), 0);
        chk("async_busy", int'(busy), 0);
        repeat (3) step();
        #1 rst_n = 1'b1;
        step();
        wait_read(10);
        chk("restart_read_en", int'(bus.bram_r_en), 1);
        chk("restart_addr", int'(bus.bram_r_addr), 0);
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
